// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-decode stage.
//   - RV32/RV64 base opcodes used by the immediate classifier
//   - imm_type_e : 3-bit immediate type tag driven on out_type
//   - xlen_legal : datapath width check used at elaboration
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_ZIMM  = 3'd7
  } imm_type_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate classifier/extractor.
//   instr_i   : raw 32-bit instruction word
//   imm_o     : sign/zero-extended XLEN-wide immediate (0 for NONE)
//   type_o    : immediate format tag
//   illegal_o : malformed shift-immediate encoding (imm_o still valid)
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  shift_hi;
  logic [31:0] imm_i32;
  logic [31:0] imm_s32;
  logic [31:0] imm_b32;
  logic [31:0] imm_u32;
  logic [31:0] imm_j32;
  logic        is_shift_f3;
  logic        shamt_sel;
  logic        shamt_wide;

  assign opcode      = instr_i[6:0];
  assign funct3      = instr_i[14:12];
  assign shift_hi    = instr_i[31:26];
  assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Formats built at 32 bits first; widening to XLEN is a signed cast.
  assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u32 = {instr_i[31:12], 12'b0};
  assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

  always_comb begin
    imm_o      = '0;
    type_o     = IMM_NONE;
    illegal_o  = 1'b0;
    shamt_sel  = 1'b0;
    shamt_wide = 1'b0;

    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        type_o = IMM_I;
        imm_o  = XLEN'($signed(imm_i32));
      end
      OPC_OP_IMM: begin
        if (is_shift_f3) begin
          shamt_sel  = 1'b1;
          shamt_wide = (XLEN == 64);
        end else begin
          type_o = IMM_I;
          imm_o  = XLEN'($signed(imm_i32));
        end
      end
      OPC_OP_IMM_32: begin
        // Word-sized ops exist only on RV64; on RV32 the opcode is NONE.
        if (XLEN == 64) begin
          if (funct3 == 3'b000) begin
            type_o = IMM_I;
            imm_o  = XLEN'($signed(imm_i32));
          end else if (is_shift_f3) begin
            shamt_sel = 1'b1;
          end
        end
      end
      OPC_STORE: begin
        type_o = IMM_S;
        imm_o  = XLEN'($signed(imm_s32));
      end
      OPC_BRANCH: begin
        type_o = IMM_B;
        imm_o  = XLEN'($signed(imm_b32));
      end
      OPC_LUI, OPC_AUIPC: begin
        type_o = IMM_U;
        imm_o  = XLEN'($signed(imm_u32));
      end
      OPC_JAL: begin
        type_o = IMM_J;
        imm_o  = XLEN'($signed(imm_j32));
      end
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          type_o = IMM_ZIMM;
          imm_o  = XLEN'(instr_i[19:15]);
        end
      end
      default: ;
    endcase

    if (shamt_sel) begin
      type_o = IMM_SHAMT;
      imm_o  = shamt_wide ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
      // Upper funct bits: SLLI needs all zero, SRLI/SRAI allow 000000/010000.
      // A 5-bit shamt with bit 25 set would be an out-of-range shift.
      illegal_o = ((funct3 == 3'b001) && (shift_hi != 6'b000000)) ||
                  ((funct3 == 3'b101) && (shift_hi != 6'b000000) &&
                   (shift_hi != 6'b010000)) ||
                  (!shamt_wide && instr_i[25]);
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode pipeline stage with a 2-entry skid buffer.
//   clk, rst_n (sync, active-low), flush (sync pipeline clear)
//   in_valid/in_ready/in_instr/in_tag   : upstream handshake + payload
//   out_valid/out_ready                 : downstream handshake
//   out_imm/out_type/out_illegal/out_tag: decoded result of the head entry
// Decode happens before the registers, so main and skid both hold results.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        ty;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t    dec_entry;
  entry_t    main_q, main_d;
  entry_t    skid_q, skid_d;
  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;
  logic      in_fire;
  logic      main_free;

  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_ill;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .type_o    (dec_type),
    .illegal_o (dec_ill)
  );

  assign dec_entry = '{imm: dec_imm, ty: dec_type, ill: dec_ill, tag: in_tag};
  assign in_fire   = in_valid && in_ready_q;
  assign main_free = !main_valid_q || out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older skid entry moves up first; a same-cycle input backfills it.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_d = dec_entry;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_d = dec_entry;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_type    = main_q.ty;
  assign out_illegal = main_q.ill;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        ir32, ov32, il32;
  logic [31:0] imm32;
  logic [2:0]  ty32;
  logic [31:0] tag32;
  logic        ir64, ov64, il64;
  logic [63:0] imm64;
  logic [2:0]  ty64;
  logic [31:0] tag64;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_type(ty32),
    .out_illegal(il32), .out_tag(tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_type(ty64),
    .out_illegal(il64), .out_tag(tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set rules, using signed
  // arithmetic shifts of the whole word to get the sign extension.
  function automatic void ref_decode(input logic [31:0] w, input int xl,
                                     output logic [63:0] imm, output logic [2:0] ty,
                                     output logic ill);
    longint s;
    longint t;
    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] hi;
    bit shift;
    bit wide;
    op = w[6:0];
    f3 = w[14:12];
    hi = w[31:26];
    s  = longint'($signed(w));
    imm = 64'd0; ty = 3'd0; ill = 1'b0; shift = 0; wide = 0;
    case (op)
      7'h03, 7'h67: begin ty = 3'd1; t = s >>> 20; imm = t; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin shift = 1; wide = (xl == 64); end
        else begin ty = 3'd1; t = s >>> 20; imm = t; end
      end
      7'h1B: begin
        if (xl == 64) begin
          if (f3 == 3'd0) begin ty = 3'd1; t = s >>> 20; imm = t; end
          else if (f3 == 3'd1 || f3 == 3'd5) shift = 1;
        end
      end
      7'h23: begin ty = 3'd2; t = s >>> 25; imm = (t << 5) | 64'(w[11:7]); end
      7'h63: begin
        ty = 3'd3; t = s >>> 31;
        imm = (t << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
      end
      7'h37, 7'h17: begin ty = 3'd4; t = s >>> 12; imm = t << 12; end
      7'h6F: begin
        ty = 3'd5; t = s >>> 31;
        imm = (t << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
      end
      7'h73: if (f3[2]) begin ty = 3'd7; imm = 64'(w[19:15]); end
      default: ;
    endcase
    if (shift) begin
      ty  = 3'd6;
      imm = wide ? 64'(w[25:20]) : 64'(w[24:20]);
      ill = (f3 == 3'd1 && hi != 6'd0) ||
            (f3 == 3'd5 && hi != 6'd0 && hi != 6'b010000) ||
            (!wide && w[25]);
    end
    if (xl == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  typedef struct {
    logic [31:0] w;
    logic [31:0] tag;
  } item_t;
  item_t q[$];

  // Model: FIFO of accepted instructions (depth 2). Head must be on the outputs,
  // occupancy decides out_valid and in_ready.
  always @(negedge clk) begin
    logic [63:0] e_imm;
    logic [2:0]  e_ty;
    logic        e_ill;
    bit mv, mr;
    if (model_on) begin
      chk("m_valid32", 64'(ov32), 64'(q.size() > 0));
      chk("m_valid64", 64'(ov64), 64'(q.size() > 0));
      chk("m_ready32", 64'(ir32), 64'(q.size() < 2));
      chk("m_ready64", 64'(ir64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        ref_decode(q[0].w, 32, e_imm, e_ty, e_ill);
        chk("m_imm32", 64'(imm32), e_imm);
        chk("m_type32", 64'(ty32), 64'(e_ty));
        chk("m_ill32", 64'(il32), 64'(e_ill));
        chk("m_tag32", 64'(tag32), 64'(q[0].tag));
        ref_decode(q[0].w, 64, e_imm, e_ty, e_ill);
        chk("m_imm64", imm64, e_imm);
        chk("m_type64", 64'(ty64), 64'(e_ty));
        chk("m_ill64", 64'(il64), 64'(e_ill));
        chk("m_tag64", 64'(tag64), 64'(q[0].tag));
      end
    end
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      mv = q.size() > 0;
      mr = q.size() < 2;
      if (mv && out_ready) void'(q.pop_front());
      if (in_valid && mr) q.push_back('{w: in_instr, tag: in_tag});
    end
  end

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    int r;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h67;
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h1B;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      6: w[6:0] = ($urandom % 2) ? 7'h37 : 7'h17;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h73;
      9, 10: begin
        w[6:0]   = (k == 9) ? 7'h13 : 7'h1B;
        w[14:12] = ($urandom % 2) ? 3'd1 : 3'd5;
        r = $urandom_range(0, 3);
        if (r == 0) w[31:26] = 6'b000000;
        else if (r == 1) w[31:26] = 6'b010000;
        else if (r == 2) w[31:26] = 6'(($urandom % 2) ? 6'b000000 : 6'b010000);
      end
      default: ;
    endcase
    return w;
  endfunction

  // Called at posedge+1 with an empty pipe and out_ready=1; checks one cycle later.
  task automatic send_one(input string nm, input logic [31:0] w, input logic [31:0] tg,
                          input logic [63:0] e_imm32, input logic [2:0] e_ty32, input logic e_il32,
                          input logic [63:0] e_imm64, input logic [2:0] e_ty64, input logic e_il64);
    in_valid = 1'b1;
    in_instr = w;
    in_tag   = tg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(ov32 & ov64), 64'd1);
    chk({nm, "_imm32"}, 64'(imm32), e_imm32);
    chk({nm, "_type32"}, 64'(ty32), 64'(e_ty32));
    chk({nm, "_ill32"}, 64'(il32), 64'(e_il32));
    chk({nm, "_imm64"}, imm64, e_imm64);
    chk({nm, "_type64"}, 64'(ty64), 64'(e_ty64));
    chk({nm, "_ill64"}, 64'(il64), 64'(e_il64));
    chk({nm, "_tag"}, 64'(tag64), 64'(tg));
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc;
    bit prev_clr;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_on = 1'b1;

    @(negedge clk);
    chk("rst_valid", 64'(ov32 | ov64), 64'd0);
    chk("rst_ready", 64'(ir32 & ir64), 64'd1);
    chk("rst_imm", imm64 | 64'(imm32), 64'd0);
    chk("rst_type", 64'(ty32 | ty64), 64'd0);
    chk("rst_ill", 64'(il32 | il64), 64'd0);
    chk("rst_tag", 64'(tag32 | tag64), 64'd0);
    @(posedge clk); #1;

    send_one("addi", 32'hFFF00093, 32'h10, 64'hFFFF_FFFF, 3'd1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    send_one("sw", 32'hFE112E23, 32'h11, 64'hFFFF_FFFC, 3'd2, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    send_one("jal", 32'h001000EF, 32'h12, 64'h800, 3'd5, 1'b0, 64'h800, 3'd5, 1'b0);
    send_one("srai", 32'h4210D093, 32'h13, 64'h01, 3'd6, 1'b1, 64'h21, 3'd6, 1'b0);
    send_one("lui", 32'h800000B7, 32'h14, 64'h8000_0000, 3'd4, 1'b0,
             64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    send_one("csrrwi", 32'h3407D0F3, 32'h15, 64'hF, 3'd7, 1'b0, 64'hF, 3'd7, 1'b0);
    send_one("addiw", 32'h0010809B, 32'h16, 64'h0, 3'd0, 1'b0, 64'h1, 3'd1, 1'b0);
    send_one("slliw", 32'h0210909B, 32'h17, 64'h0, 3'd0, 1'b0, 64'h1, 3'd6, 1'b1);

    // Stall: three back-to-back offers with out_ready low for three edges.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd100;
    @(posedge clk); #1 in_instr = 32'hFE112E23; in_tag = 32'd101;
    @(posedge clk); #1 in_instr = 32'h001000EF; in_tag = 32'd102;
    @(negedge clk);
    chk("stall_ready_low", 64'(ir32), 64'd0);
    chk("stall_head", 64'(tag32), 64'd100);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("stall_hold", 64'(tag32), 64'd100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_second", 64'(tag32), 64'd101);
    chk("stall_ready_back", 64'(ir32), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stall_third", 64'(tag64), 64'd102);
    chk("stall_third_valid", 64'(ov64), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_drained", 64'(ov32), 64'd0);
    @(posedge clk); #1;

    // Flush with both registers full and a third instruction offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00108093; in_tag = 32'd200;
    @(posedge clk); #1 in_instr = 32'h00208093; in_tag = 32'd201;
    @(posedge clk); #1 in_instr = 32'h00308093; in_tag = 32'd202; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(ov32 | ov64), 64'd0);
    chk("flush_ready", 64'(ir32 & ir64), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_gone", 64'(ov32 | ov64), 64'd0);
    end
    @(posedge clk); #1;

    // Reset during a stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_tag = 32'd300;
    @(posedge clk); #1 in_tag = 32'd301; in_instr = 32'h001000EF;
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 64'(ov32 | ov64), 64'd0);
    chk("rstmid_ready", 64'(ir32 & ir64), 64'd1);
    chk("rstmid_type", 64'(ty32 | ty64), 64'd0);
    chk("rstmid_imm", imm64, 64'd0);
    @(posedge clk); #1;
    send_one("resume", 32'hFFF00093, 32'd400, 64'hFFFF_FFFF, 3'd1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);

    // Random traffic with backpressure, occasional flush and reset.
    prev_clr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = in_valid && ir32;
      @(posedge clk); #1;
      if (acc || !in_valid || prev_clr) begin
        in_valid = ($urandom % 4) != 0;
        in_instr = gen_instr();
        in_tag   = $urandom;
      end
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 64) == 0;
      rst_n     = ($urandom % 256) != 0;
      prev_clr  = flush || !rst_n;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_empty", 64'(ov32 | ov64), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage for the RV32/RV64 integer core. It takes one instruction per cycle over a valid/ready handshake and classifies its immediate format. It emits a single sign/zero-extended XLEN-wide immediate with a type tag and a shift-amount legality flag. A 2-entry skid buffer gives full throughput under backpressure; the stage sits between fetch-align and the register-read/issue stage.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- TAG_W, 32: width of the opaque sideband (typically PC) carried with each instruction.
- clk  in  1  stage clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  decoded immediate.
- out_type  out  3  immediate type: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ZIMM=7.
- out_illegal  out  1  malformed shift-immediate encoding.
- out_tag  out  TAG_W  sideband of the same instruction.

## Operation
- Opcode classification:
  - I: LOAD 0000011, JALR 1100111, OP-IMM 0010011 except funct3 001/101.
  - I (XLEN=64 only): OP-IMM-32 0011011 funct3 000.
  - S: 0100011.
  - B: 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: 1101111.
  - SHAMT: OP-IMM funct3 001/101; OP-IMM-32 funct3 001/101 only when XLEN=64.
  - ZIMM: SYSTEM 1110011 with funct3[2]=1.
  - Everything else is NONE: out_imm=0, out_illegal=0.
- Extension rules:
  - I/S/B/J are sign-extended from instr[31] to XLEN.
  - U is {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN.
  - ZIMM is instr[19:15] zero-extended.
- SHAMT rules:
  - OP-IMM at XLEN=64 yields instr[25:20] zero-extended.
  - All other SHAMT cases yield instr[24:20] zero-extended.
  - out_illegal=1 when funct3=001 and instr[31:26]≠0, or funct3=101 and instr[31:26]∉{000000,010000}.
  - out_illegal=1 when the shamt width is 5 and instr[25]=1.
  - out_imm is still produced when illegal.
- Handshake:
  - A transfer occurs on in_valid&&in_ready and on out_valid&&out_ready.
  - in_valid and payload must stay stable until accepted.
  - out_* stay stable while out_valid&&!out_ready.
- Buffering: a main output register plus one skid register; strict FIFO order, no drops, no duplicates.
  - Main empty, or main being consumed: main loads from skid if the skid is valid, else from the accepted input.
  - Main full and stalled with an input accepted: the input goes to the skid.
  - in_ready(next) = !skid_valid(next).
- Flush (priority below reset, above everything else): clears main and skid valid; any input accepted in the same cycle is discarded; in_ready=1 next cycle.

## Timing
- Latency: an instruction accepted at edge N appears on out_* after edge N (1 cycle), when the main register is free.
- Throughput: 1 instruction/cycle with out_ready held high.
- A stall of any length loses nothing; in_ready falls the cycle after the skid fills and rises the cycle after it drains.
- Reset values: out_valid=0, skid empty, in_ready=1, out_imm=0, out_type=NONE, out_illegal=0, out_tag=0.
- Reset asserted mid-stall discards all held instructions.
- Simultaneous out-consume and in-accept with the skid valid: skid→main, input→skid, order preserved.

## Structure
- Package imm_pkg:
  - opcode localparams.
  - 3-bit imm_type_e enum.
  - XLEN legality check (elaboration error if XLEN∉{32,64}).
- Sub-module imm_extract (combinational, parameter XLEN): instr → {imm, type, illegal}. It is instantiated once, on the input side, so both registers hold decoded results.
- Top level holds the main/skid registers and handshake control only.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → one cycle later out_type=I, out_imm=0xFFFFFFFF, out_illegal=0.
- 0xFE112E23 (sw x1,-4(x2)) → out_type=S, out_imm=0xFFFFFFFC; then 0x001000EF (jal x1,2048) → out_type=J, out_imm=0x00000800.
- XLEN=64, 0x4210D093 (srai x1,x1,33) → out_type=SHAMT, out_imm=0x21, out_illegal=0.
  - Same word at XLEN=32 → out_imm=0x01, out_illegal=1.
- out_ready low 3 cycles while 3 back-to-back instructions are offered:
  - in_ready=0 after the second accept.
  - The third is held at the input.
  - On release, outputs arrive in order, one per cycle.
  - No gaps, no loss.
- flush asserted with main and skid full and in_valid=1 → next cycle out_valid=0, in_ready=1; none of the three instructions ever appears.
- rst_n low for one cycle during a stall → out_valid=0, in_ready=1, out_type=NONE after the edge; normal flow resumes immediately after.
